// File: rtl/sam_pkg.sv
// Shared SAM-side definitions for the CPU clock scheduler:
// rate encodings, FSM state type and default cycle divisors.
package sam_pkg;

    localparam logic [1:0] RATE_SLOW = 2'b00;
    localparam logic [1:0] RATE_ADDR = 2'b01;
    localparam logic [1:0] RATE_FAST = 2'b1x;

    localparam int DEF_SLOW_DIV = 16;
    localparam int DEF_FAST_DIV = 8;
    localparam int DEF_CW       = 5;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        RUN_SLOW = 2'd1,
        RUN_FAST = 2'd2
    } cpu_state_t;

endpackage

// File: rtl/cpu_rate_sched_if.sv
// SAM register side / E-Q pin side bundle for the CPU clock scheduler.
// The master drives the rate request and observes the generated clocks.
interface cpu_rate_sched_if;

    logic [1:0] rate;
    logic       addr_fast;
    logic       e_out;
    logic       q_out;
    logic       cyc_start;
    logic       cyc_fast;
    logic       vid_slot;

    modport master (
        output rate, addr_fast,
        input  e_out, q_out, cyc_start, cyc_fast, vid_slot
    );

    modport slave (
        input  rate, addr_fast,
        output e_out, q_out, cyc_start, cyc_fast, vid_slot
    );

endinterface

// File: rtl/cyc_phase_ctr.sv
// Modulo-N phase counter for one CPU cycle; i_load forces the next phase to 0
// and o_tc flags the last phase so the owner can pick the next cycle length.
module cyc_phase_ctr #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_last,
    output logic [CW-1:0] o_phNext,
    output logic          o_tc
);

    logic [CW-1:0] r_ph;

    assign o_tc = (r_ph == i_last);

    always_comb begin
        o_phNext = r_ph + CW'(1);
        if (i_load || o_tc) begin
            o_phNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph <= '0;
        end else begin
            r_ph <= o_phNext;
        end
    end

endmodule

// File: rtl/cpu_rate_sched.sv
// 6809 E/Q clock generator: one CPU cycle at a time, slow or fast, with the
// cycle length chosen only at the cycle boundary so E and Q never glitch.
module cpu_rate_sched
    import sam_pkg::*;
#(
    parameter int SLOW_DIV = DEF_SLOW_DIV,
    parameter int FAST_DIV = DEF_FAST_DIV,
    parameter int CW       = DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    cpu_rate_sched_if.slave  bus
);

    localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] SLOW_QTR  = CW'(SLOW_DIV / 4);
    localparam logic [CW-1:0] SLOW_HALF = CW'(SLOW_DIV / 2);
    localparam logic [CW-1:0] SLOW_Q3   = CW'((3 * SLOW_DIV) / 4);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] FAST_QTR  = CW'(FAST_DIV / 4);
    localparam logic [CW-1:0] FAST_HALF = CW'(FAST_DIV / 2);
    localparam logic [CW-1:0] FAST_Q3   = CW'((3 * FAST_DIV) / 4);

    cpu_state_t    r_state;
    cpu_state_t    w_stateNext;
    logic [CW-1:0] w_phNext;
    logic [CW-1:0] w_last;
    logic          w_tc;
    logic          w_fastPick;
    logic          w_nextFast;
    logic [CW-1:0] w_qtr;
    logic [CW-1:0] w_half;
    logic [CW-1:0] w_q3;
    logic          r_e;
    logic          r_q;
    logic          r_cs;
    logic          r_cf;
    logic          r_vid;

    // The current state is the latched cycle length; it only moves at ph = N-1.
    assign w_last = (r_state == RUN_FAST) ? FAST_LAST : SLOW_LAST;

    cyc_phase_ctr #(
        .CW(CW)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .i_load   (r_state == RST_WAIT),
        .i_last   (w_last),
        .o_phNext (w_phNext),
        .o_tc     (w_tc)
    );

    always_comb begin
        w_fastPick = 1'b0;
        if (bus.rate ==? RATE_FAST) begin
            w_fastPick = 1'b1;
        end else if (bus.rate == RATE_ADDR) begin
            w_fastPick = bus.addr_fast;
        end else if (bus.rate == RATE_SLOW) begin
            w_fastPick = 1'b0;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            RST_WAIT: w_stateNext = RUN_SLOW;
            default: begin
                if (w_tc) begin
                    w_stateNext = w_fastPick ? RUN_FAST : RUN_SLOW;
                end
            end
        endcase
    end

    assign w_nextFast = (w_stateNext == RUN_FAST);
    assign w_qtr      = w_nextFast ? FAST_QTR  : SLOW_QTR;
    assign w_half     = w_nextFast ? FAST_HALF : SLOW_HALF;
    assign w_q3       = w_nextFast ? FAST_Q3   : SLOW_Q3;

    // Decode from the next phase so every registered edge lands on its own phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_WAIT;
            r_e     <= 1'b0;
            r_q     <= 1'b0;
            r_cs    <= 1'b0;
            r_cf    <= 1'b0;
            r_vid   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_e     <= (w_phNext >= w_half);
            r_q     <= (w_phNext >= w_qtr) && (w_phNext < w_q3);
            r_cs    <= (w_phNext == '0);
            r_cf    <= w_nextFast;
            r_vid   <= (w_stateNext == RUN_SLOW) && (w_phNext < w_half);
        end
    end

    assign bus.e_out     = r_e;
    assign bus.q_out     = r_q;
    assign bus.cyc_start = r_cs;
    assign bus.cyc_fast  = r_cf;
    assign bus.vid_slot  = r_vid;

endmodule

// File: tb/tb_cpu_rate_sched.sv
// Directed bench for cpu_rate_sched: reset, steady slow, slow->fast, address-dependent
// rate, mid-cycle reset and alternating rates, checked phase by phase.
module tb_cpu_rate_sched;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cpu_rate_sched_if bus();

    cpu_rate_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic monOn = 1'b0;
    logic prevE, prevQ, eSeen, qSeen;
    int   eRun, qRun, minW, eRises;

    // Pulse-width and E-rise monitor for the alternating-rate run; partial first runs are skipped.
    always @(negedge clk) begin
        if (monOn) begin
            if (bus.e_out && !prevE) eRises++;
            if (bus.e_out != prevE) begin
                if (eSeen && eRun < minW) minW = eRun;
                eSeen = 1'b1;
                eRun  = 1;
            end else begin
                eRun++;
            end
            if (bus.q_out != prevQ) begin
                if (qSeen && qRun < minW) minW = qRun;
                qSeen = 1'b1;
                qRun  = 1;
            end else begin
                qRun++;
            end
            prevE = bus.e_out;
            prevQ = bus.q_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] rt, input logic af);
        rst           = r;
        bus.rate      = rt;
        bus.addr_fast = af;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] outs();
        return {3'b000, bus.e_out, bus.q_out, bus.cyc_start, bus.cyc_fast, bus.vid_slot};
    endfunction

    // Expected {e, q, cyc_start, cyc_fast, vid_slot} at a given phase of a slow or fast cycle.
    function automatic logic [7:0] expOut(input logic fast, input int ph);
        int n;
        n = fast ? 8 : 16;
        return {3'b000, ph >= n / 2, (ph >= n / 4) && (ph < (3 * n) / 4), ph == 0,
                fast, !fast && (ph < n / 2)};
    endfunction

    // Walks nWalk phases from ph=0; events are {rst, rate[1:0], addr_fast} applied after a phase.
    task automatic checkCycle(input string tag, input logic fast, input int nWalk,
                              input int ev1Ph, input logic [3:0] ev1,
                              input int ev2Ph, input logic [3:0] ev2);
        for (int ph = 0; ph < nWalk; ph++) begin
            checkOutput($sformatf("%s_ph%0d", tag, ph), outs(), expOut(fast, ph));
            if (ph == ev1Ph) applyStimulus(ev1[3], ev1[2:1], ev1[0]);
            if (ph == ev2Ph) applyStimulus(ev2[3], ev2[2:1], ev2[0]);
            tick();
        end
    endtask

    initial begin
        logic fast;

        $display("[TB] reset and first cycle");
        applyStimulus(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("T1_rst%0d", i), outs(), 8'h00);
        end
        applyStimulus(1'b0, 2'b11, 1'b0);
        tick();
        checkOutput("T1_release", outs(), 8'b0000_0101);
        checkCycle("T1_first", 1'b0, 16, 3, 4'b0000, -1, 4'b0000);

        $display("[TB] steady slow");
        checkCycle("T2_c2", 1'b0, 16, -1, 4'b0000, -1, 4'b0000);
        checkCycle("T2_c3", 1'b0, 16, -1, 4'b0000, -1, 4'b0000);

        $display("[TB] slow to fast mid-cycle request");
        checkCycle("T3_c4", 1'b0, 16, 5, 4'b0110, -1, 4'b0000);
        checkCycle("T3_c5", 1'b1, 8, -1, 4'b0000, -1, 4'b0000);
        checkCycle("T3_c6", 1'b1, 8, 2, 4'b0010, -1, 4'b0000);

        $display("[TB] address-dependent rate");
        checkCycle("T4_k",  1'b0, 16, 10, 4'b0011, -1, 4'b0000);
        checkCycle("T4_k1", 1'b1, 8, 2, 4'b0010, -1, 4'b0000);
        checkCycle("T4_k2", 1'b0, 16, 3, 4'b0011, 9, 4'b0010);
        checkCycle("T4_k3", 1'b0, 16, -1, 4'b0000, -1, 4'b0000);

        $display("[TB] reset in the middle of a slow cycle");
        checkCycle("T5_pre", 1'b0, 10, 9, 4'b1010, -1, 4'b0000);
        checkOutput("T5_rst_e", {7'b0, bus.e_out}, 8'h00);
        checkOutput("T5_rst_all", outs(), 8'h00);
        applyStimulus(1'b0, 2'b00, 1'b0);
        tick();
        checkCycle("T5_after", 1'b0, 16, -1, 4'b0000, -1, 4'b0000);

        $display("[TB] alternating slow/fast");
        eSeen  = 1'b0;
        qSeen  = 1'b0;
        eRun   = 0;
        qRun   = 0;
        prevE  = bus.e_out;
        prevQ  = bus.q_out;
        eRises = 0;
        minW   = 1000;
        monOn  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            fast = ((i % 2) == 1);
            checkCycle($sformatf("T6_c%0d", i), fast, fast ? 8 : 16,
                       1, fast ? 4'b0000 : 4'b0110, -1, 4'b0000);
        end
        monOn = 1'b0;
        checkOutput("T6_e_rises", 8'(eRises), 8'd50);
        checkOutput("T6_min_pulse", 8'(minW), 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
